// File: rtl/rx_quadro.sv
// Serial frame receiver: start 0, LD data bits, LI instruction bits (LSB first), end marker 0.
// One bit per clk, same clock domain as the transmitter, so the line is sampled directly.
module rx_quadro #(
  parameter int LARGURA_DADO  = 4,
  parameter int LARGURA_INSTR = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     info_entrada,
  output logic [LARGURA_DADO-1:0]  dado_rx,
  output logic [LARGURA_INSTR-1:0] instrucao_rx,
  output logic                     valido,
  output logic                     erro_quadro,
  output logic                     ocupado,
  output logic [7:0]               cont_quadros
);

  localparam int LT = LARGURA_DADO + LARGURA_INSTR;
  localparam int CW = (LT > 1) ? $clog2(LT) : 1;
  localparam logic [CW-1:0] N_ULTIMO = CW'(LT - 1);
  localparam logic [CW-1:0] N_UM     = CW'(1);

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    RECEBE       = 2'd1,
    FIM          = 2'd2,
    AGUARDA_ALTO = 2'd3
  } estado_t;

  estado_t                  estado_q, estado_d;
  logic [CW-1:0]            n_q, n_d;
  logic [LT-1:0]            sr_q, sr_d;
  logic [LARGURA_DADO-1:0]  dado_q, dado_d;
  logic [LARGURA_INSTR-1:0] instr_q, instr_d;
  logic                     valido_q, valido_d;
  logic                     erro_q, erro_d;
  logic                     ocupado_q, ocupado_d;
  logic [7:0]               cont_q, cont_d;

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q  <= OCIOSO;
      n_q       <= '0;
      sr_q      <= '0;
      dado_q    <= '0;
      instr_q   <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
      cont_q    <= 8'd0;
    end else begin
      estado_q  <= estado_d;
      n_q       <= n_d;
      sr_q      <= sr_d;
      dado_q    <= dado_d;
      instr_q   <= instr_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
      ocupado_q <= ocupado_d;
      cont_q    <= cont_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    estado_d = estado_q;
    n_d      = n_q;
    sr_d     = sr_q;
    dado_d   = dado_q;
    instr_d  = instr_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    cont_d   = cont_q;
    case (estado_q)
      OCIOSO: begin
        if (!info_entrada) begin
          estado_d = RECEBE;
          n_d      = '0;
        end else begin
          estado_d = OCIOSO;
        end
      end
      RECEBE: begin
        sr_d[n_q] = info_entrada;
        if (n_q == N_ULTIMO) begin
          estado_d = FIM;
        end else begin
          n_d = n_q + N_UM;
        end
      end
      FIM: begin
        if (!info_entrada) begin
          dado_d   = sr_q[LARGURA_DADO-1:0];
          instr_d  = sr_q[LT-1:LARGURA_DADO];
          valido_d = 1'b1;
          cont_d   = cont_q + 8'd1;
          estado_d = AGUARDA_ALTO;
        end else begin
          erro_d   = 1'b1;
          estado_d = OCIOSO;
        end
      end
      AGUARDA_ALTO: begin
        // A low line after a frame is the tail of that frame, never a new start.
        if (info_entrada) begin
          estado_d = OCIOSO;
        end else begin
          estado_d = AGUARDA_ALTO;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
    ocupado_d = (estado_d != OCIOSO);
  end

  assign dado_rx      = dado_q;
  assign instrucao_rx = instr_q;
  assign valido       = valido_q;
  assign erro_quadro  = erro_q;
  assign ocupado      = ocupado_q;
  assign cont_quadros = cont_q;

endmodule

// File: tb/tb_rx_quadro.sv
// Scoreboard bench for rx_quadro: frames are built from the line format, expected
// results are queued at stimulus time and a negedge monitor pops them on each pulse.
module tb_rx_quadro;
  localparam int LD = 4;
  localparam int LI = 4;

  typedef struct {
    bit         err;
    logic [3:0] d;
    logic [3:0] i;
    logic [7:0] c;
    int         t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          info_entrada = 1'b1;
  logic [LD-1:0] dado_rx;
  logic [LI-1:0] instrucao_rx;
  logic          valido;
  logic          erro_quadro;
  logic          ocupado;
  logic [7:0]    cont_quadros;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cnt_model = 0;
  exp_t sb[$];

  rx_quadro #(.LARGURA_DADO(LD), .LARGURA_INSTR(LI)) dut (
    .clk          (clk),
    .rst          (rst),
    .info_entrada (info_entrada),
    .dado_rx      (dado_rx),
    .instrucao_rx (instrucao_rx),
    .valido       (valido),
    .erro_quadro  (erro_quadro),
    .ocupado      (ocupado),
    .cont_quadros (cont_quadros)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    info_entrada = b;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send_bit(1'b1);
  endtask

  // One complete frame; the expected outcome is queued before the bits go out.
  task automatic frame(input logic [3:0] d, input logic [3:0] i, input bit bad_end);
    exp_t e;
    @(negedge clk);
    info_entrada = 1'b0;
    e.t   = cyc + 10;
    e.err = bad_end;
    e.d   = d;
    e.i   = i;
    if (!bad_end) cnt_model = (cnt_model + 1) % 256;
    e.c = 8'(cnt_model);
    sb.push_back(e);
    for (int k = 0; k < LD; k++) begin
      send_bit(d[k]);
      if (k == 0) chk("ocupado_in_frame", 32'(ocupado), 32'd1);
    end
    for (int k = 0; k < LI; k++) send_bit(i[k]);
    send_bit(bad_end);
  endtask

  // Monitor: pops the scoreboard on every pulse and checks the held fields each cycle.
  initial begin : monitor
    exp_t       e;
    logic [3:0] exp_d;
    logic [3:0] exp_i;
    logic [7:0] exp_c;
    exp_d = 4'd0;
    exp_i = 4'd0;
    exp_c = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_d = 4'd0;
        exp_i = 4'd0;
        exp_c = 8'd0;
      end else begin
        chk("valido_and_erro", 32'(valido & erro_quadro), 32'd0);
        if (valido || erro_quadro) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got valido=%0b erro=%0b expected no pulse (cycle %0d)",
                     valido, erro_quadro, cyc);
          end else begin
            e = sb.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(e.t));
            chk("pulse_kind_erro", 32'(erro_quadro), 32'(e.err));
            if (!e.err) begin
              exp_d = e.d;
              exp_i = e.i;
              exp_c = e.c;
            end
          end
        end
        chk("dado_rx", 32'(dado_rx), 32'(exp_d));
        chk("instrucao_rx", 32'(instrucao_rx), 32'(exp_i));
        chk("cont_quadros", 32'(cont_quadros), 32'(exp_c));
      end
    end
  end

  initial begin : stimulus
    logic [3:0] rd;
    logic [3:0] ri;
    bit         rbad;

    rst = 1'b0;
    info_entrada = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valido", 32'(valido), 32'd0);
    chk("reset_erro", 32'(erro_quadro), 32'd0);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_dado", 32'(dado_rx), 32'd0);
    chk("reset_cont", 32'(cont_quadros), 32'd0);
    rst = 1'b1;

    for (int k = 0; k < 20; k++) begin
      send_bit(1'b1);
      chk("idle_ocupado", 32'(ocupado), 32'd0);
    end

    frame(4'hA, 4'h5, 1'b0);
    idle(1);
    frame(4'hA, 4'h5, 1'b1);
    idle(1);
    chk("ocupado_after_error", 32'(ocupado), 32'd0);
    frame(4'h6, 4'h9, 1'b0);
    idle(1);

    frame(4'h3, 4'hC, 1'b0);
    idle(1);
    frame(4'hF, 4'h0, 1'b0);
    idle(1);

    // Line stuck low after a good frame must not be read as a new start.
    frame(4'h2, 4'hE, 1'b0);
    for (int k = 0; k < 30; k++) begin
      send_bit(1'b0);
      chk("hold_low_ocupado", 32'(ocupado), 32'd1);
    end
    idle(2);
    chk("ocupado_after_hold", 32'(ocupado), 32'd0);
    frame(4'hB, 4'h4, 1'b0);
    idle(1);

    // Reset in the middle of a frame.
    @(negedge clk);
    info_entrada = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    info_entrada = 1'b0;
    rst = 1'b0;
    cnt_model = 0;
    #1;
    chk("midreset_dado", 32'(dado_rx), 32'd0);
    chk("midreset_instr", 32'(instrucao_rx), 32'd0);
    chk("midreset_cont", 32'(cont_quadros), 32'd0);
    chk("midreset_ocupado", 32'(ocupado), 32'd0);
    chk("midreset_valido", 32'(valido), 32'd0);
    repeat (2) @(negedge clk);
    info_entrada = 1'b1;
    rst = 1'b1;
    idle(1);
    frame(4'h7, 4'h9, 1'b0);
    idle(1);

    for (int n = 0; n < 200; n++) begin
      rd   = 4'($urandom_range(0, 15));
      ri   = 4'($urandom_range(0, 15));
      rbad = ($urandom_range(0, 5) == 0);
      frame(rd, ri, rbad);
      if (!rbad && ($urandom_range(0, 3) == 0)) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) send_bit(1'b0);
      end
      idle(int'($urandom_range(1, 3)));
    end

    // Drive good frames until the counter wraps back to zero.
    do begin
      rd = 4'($urandom_range(0, 15));
      ri = 4'($urandom_range(0, 15));
      frame(rd, ri, 1'b0);
      idle(1);
    end while (cnt_model != 0);
    idle(1);
    chk("cont_wrap", 32'(cont_quadros), 32'd0);

    idle(5);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
